// File: rtl/stack_reader.sv
// -----------------------------------------------------------------------------
// stack_reader
//
// Drains an attached 2-bit LIFO stack and delivers each entry downstream
// over a valid/ready handshake. Every entry goes through three states:
// POP (request one pop), WAIT (let the stack present its data), and
// SEND (hold the entry until it is accepted). The design counts the
// accepted entries and pulses `done` once the stack has been emptied.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous, active-high reset
//   start      in   begin a drain; only sampled in IDLE
//   stk_pop    out  pop request to the stack (combinational)
//   stk_empty  in   stack empty flag
//   stk_data   in   stack data_out, updated on the edge that accepts a pop
//   out_valid  out  out_data holds a popped entry
//   out_ready  in   downstream accepts out_data on an edge with out_valid=1
//   out_data   out  popped entry, in LIFO order
//   out_last   out  out_data is the final entry (stack empty after its pop)
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse at the end of a drain
//   count      out  entries delivered in the current/last drain (saturating)
// -----------------------------------------------------------------------------
module stack_reader #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             stk_pop,
  input  logic             stk_empty,
  input  logic [1:0]       stk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       data_q,  data_d;
  logic             last_q,  last_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state and output logic.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    last_d    = last_q;
    count_d   = count_q;
    stk_pop   = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = '0;
          state_d = S_POP;
        end
      end

      S_POP: begin
        // An empty stack ends the drain without touching the stack at all.
        if (stk_empty) begin
          state_d = S_DONE;
        end else begin
          stk_pop = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // The stack has just applied the pop: stk_data is the popped entry
        // and stk_empty already tells whether it was the bottom one.
        data_d  = stk_data;
        last_d  = stk_empty;
        state_d = S_SEND;
      end

      S_SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_ONE;
          end
          state_d = last_q ? S_DONE : S_POP;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset wins over every other input.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign out_data = data_q;
  assign out_last = last_q;
  assign count    = count_q;

endmodule

// File: tb/tb_stack_reader.sv
// -----------------------------------------------------------------------------
// tb_stack_reader
//
// Bench for stack_reader. A behavioural 2-bit stack (256 deep) drives the
// DUT. On each accepted start the reference model snapshots the stack
// contents, top first, into a queue. Every cycle the compare process checks
// the DUT against that queue and the drain rules: entry and last flag,
// count, busy, done timing, and pop legality. Directed scenarios add literal
// expectations, and a randomized phase covers random sizes, data,
// back-pressure and start noise.
// -----------------------------------------------------------------------------
module tb_stack_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
  logic       stk_pop;
  logic       stk_empty;
  logic [1:0] stk_data;
  logic       out_valid;
  logic [1:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;
  logic [8:0] count;

  always #5 clk = ~clk;

  stack_reader #(.CNT_W(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stk_pop   (stk_pop),
    .stk_empty (stk_empty),
    .stk_data  (stk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural stack ----------------
  logic [1:0] stk_mem [256];
  int         stk_top = 0;
  logic [1:0] stk_data_r = 2'b00;
  logic       ld_en = 1'b0;
  logic       ld_clr = 1'b0;
  logic [1:0] ld_val = 2'b00;

  always @(posedge clk) begin
    if (ld_clr) begin
      stk_top <= 0;
    end else if (ld_en) begin
      stk_mem[stk_top] <= ld_val;
      stk_top          <= stk_top + 1;
    end else if (stk_pop && stk_top > 0) begin
      stk_data_r <= stk_mem[stk_top-1];
      stk_top    <= stk_top - 1;
    end
  end

  assign stk_empty = (stk_top == 0);
  assign stk_data  = stk_data_r;

  // ---------------- reference model + compare process ----------------
  logic       mon_en = 1'b0;
  logic [1:0] q [$];          // entries still owed, front = next expected
  logic [1:0] log_d [$];      // accepted entries, append-only
  bit         log_l [$];
  bit         m_busy = 0;
  bit         m_done_now = 0;
  int         m_cnt = 0;
  int         done_in = 0;
  int         drain_n = 0;
  int         pops = 0;
  int         tot_pops = 0;
  int         done_cnt = 0;
  int         valid_cyc = 0;
  bit         prev_stall = 0;
  bit         cur_busy;
  bit         next_done;
  int         n_hot;

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done_now);
      check("count", count, m_cnt);
      n_hot = int'(out_valid) + int'(done) + int'(stk_pop);
      check("exclusive_valid_done_pop", n_hot <= 1, 1);
      if (stk_pop) begin
        check("pop_on_nonempty", stk_empty, 0);
        check("pop_while_busy", m_busy, 1);
        pops++;
        tot_pops++;
      end
      if (prev_stall) check("stall_hold_valid", out_valid, 1);
      if (out_valid) begin
        valid_cyc++;
        if (q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          check("out_data", out_data, q[0]);
          check("out_last", out_last, q.size() == 1);
        end
      end
      if (done) begin
        done_cnt++;
        check("pops_per_drain", pops, drain_n);
      end
      prev_stall = out_valid && !out_ready && !rst;

      // Advance the model across the coming edge.
      if (rst) begin
        m_busy     = 0;
        m_done_now = 0;
        m_cnt      = 0;
        done_in    = 0;
        pops       = 0;
        drain_n    = 0;
        q.delete();
      end else begin
        cur_busy  = m_busy;
        next_done = 0;
        if (m_done_now) m_busy = 0;
        if (done_in > 0) begin
          done_in--;
          if (done_in == 0) next_done = 1;
        end
        if (!cur_busy && start) begin
          q.delete();
          for (int i = stk_top - 1; i >= 0; i--) q.push_back(stk_mem[i]);
          m_cnt   = 0;
          m_busy  = 1;
          pops    = 0;
          drain_n = q.size();
          if (q.size() == 0) done_in = 1;
        end else if (cur_busy && out_valid && out_ready && q.size() > 0) begin
          log_d.push_back(out_data);
          log_l.push_back(out_last);
          void'(q.pop_front());
          if (m_cnt < 511) m_cnt++;
          if (q.size() == 0) next_done = 1;
        end
        m_done_now = next_done;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit rdy_rand   = 0;
  bit start_noise = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] v);
    ld_en  = 1'b1;
    ld_val = v;
    tick();
    ld_en  = 1'b0;
  endtask

  task automatic clear_stack();
    ld_clr = 1'b1;
    tick();
    ld_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int  base;
    bit  seen;
    base = done_cnt;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done_cnt > base) begin
        seen = 1;
      end else begin
        if (rdy_rand)    out_ready = 1'($urandom_range(0, 1));
        if (start_noise) start     = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    if (!seen) check({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (out_valid) seen = 1;
      else tick();
    end
    if (!seen) check({name, "_valid_timeout"}, 0, 1);
  endtask

  int lb, db, vb, pb, n;

  initial begin
    // Reset.
    rst    = 1'b1;
    ld_clr = 1'b1;
    tick();
    tick();
    ld_clr = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_stk_pop", stk_pop, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick();

    // Three entries, bottom..top 01,10,11, always ready.
    push(2'b01); push(2'b10); push(2'b11);
    out_ready = 1'b1;
    lb = log_d.size();
    pulse_start();
    wait_done(40, "lifo3");
    check("lifo3_n", log_d.size() - lb, 3);
    check("lifo3_d0", log_d[lb],   2'b11);
    check("lifo3_d1", log_d[lb+1], 2'b10);
    check("lifo3_d2", log_d[lb+2], 2'b01);
    check("lifo3_l0", log_l[lb],   0);
    check("lifo3_l1", log_l[lb+1], 0);
    check("lifo3_l2", log_l[lb+2], 1);
    check("lifo3_count", count, 3);
    check("lifo3_idle", busy, 0);

    // Empty stack: IDLE -> POP -> DONE.
    vb = valid_cyc; pb = tot_pops;
    pulse_start();
    check("empty_pop_state_done", done, 0);
    check("empty_pop_state_busy", busy, 1);
    tick();
    check("empty_done_pulse", done, 1);
    tick();
    check("empty_done_gone", done, 0);
    check("empty_idle", busy, 0);
    check("empty_count", count, 0);
    check("empty_no_valid", valid_cyc - vb, 0);
    check("empty_no_pop", tot_pops - pb, 0);

    // One entry, held off for 5 SEND cycles.
    push(2'b10);
    out_ready = 1'b0;
    vb = valid_cyc;
    pulse_start();
    wait_valid(10, "stall");
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 2'b10);
      check("stall_last", out_last, 1);
      tick();
    end
    out_ready = 1'b1;
    wait_done(10, "stall");
    check("stall_valid_cycles", valid_cyc - vb, 6);
    check("stall_count", count, 1);

    // 256 alternating entries, random ready.
    for (int i = 0; i < 256; i++) push((i % 2) ? 2'b11 : 2'b00);
    lb = log_d.size(); pb = tot_pops;
    rdy_rand = 1;
    pulse_start();
    wait_done(6000, "deep");
    rdy_rand = 0;
    check("deep_count", count, 256);
    check("deep_n", log_d.size() - lb, 256);
    check("deep_pops", tot_pops - pb, 256);
    check("deep_first", log_d[lb], 2'b11);
    check("deep_final", log_d[lb+255], 2'b00);

    // Reset in SEND during a 4-entry drain.
    push(2'b00); push(2'b01); push(2'b10); push(2'b11);
    out_ready = 1'b0;
    db = done_cnt;
    pulse_start();
    wait_valid(10, "midrst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_last", out_last, 0);
    check("midrst_count", count, 0);
    check("midrst_pop", stk_pop, 0);
    tick();
    check("midrst_no_done", done_cnt - db, 0);
    lb = log_d.size();
    out_ready = 1'b1;
    pulse_start();
    wait_done(40, "midrst");
    check("midrst_rest_n", log_d.size() - lb, 3);
    check("midrst_rest_d0", log_d[lb], 2'b10);
    check("midrst_rest_d2", log_d[lb+2], 2'b00);
    check("midrst_rest_count", count, 3);
    check("midrst_one_done", done_cnt - db, 1);

    // start pulsed repeatedly while busy.
    push(2'($urandom_range(0, 3))); push(2'($urandom_range(0, 3))); push(2'($urandom_range(0, 3)));
    db = done_cnt;
    rdy_rand = 1; start_noise = 1;
    pulse_start();
    wait_done(200, "restart");
    check("restart_one_done", done_cnt - db, 1);
    check("restart_count", count, 3);

    // Randomized drains.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) push(2'($urandom_range(0, 3)));
      db = done_cnt;
      pulse_start();
      wait_done(400, "rand");
      check("rand_count", count, n);
      check("rand_one_done", done_cnt - db, 1);
    end
    rdy_rand = 0; start_noise = 0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
